sram_read_tracker: RTL and testbench
====================================

SRAM_READ_TRACKER -- requirements
Module: sram_read_tracker

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8, meaning depth of the in-order read tag queue (power of two, at least 2).
REQ-002 SHALL have parameter CREDITS, default 16, meaning the per-port read-data FIFO capacity in words (at most 255).
REQ-003 SHALL have port sram_clock, in, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, in, 1: synchronous, active-high reset, sampled on sram_clock.
REQ-005 SHALL have port issue_valid, in, 1: the arbiter requests to issue an SRAM read.
REQ-006 SHALL have port issue_port, in, 1: requester of the read; 0 = r0, 1 = r1.
REQ-007 SHALL have port issue_ready, out, 1: the read may be issued this cycle.
REQ-008 SHALL have port sram_data_out, in, 32: read data returned by the SRAM.
REQ-009 SHALL have port sram_data_out_valid, in, 1: sram_data_out is valid this cycle.
REQ-010 SHALL have ports r0_data_din and r1_data_din, out, 32 each: write data to the r0 and r1 data FIFOs.
REQ-011 SHALL have ports r0_data_wr_en and r1_data_wr_en, out, 1 each: write strobes to the r0 and r1 data FIFOs.
REQ-012 SHALL have ports r0_credit_ret and r1_credit_ret, in, 1 each: one pulse per word popped from that port's data FIFO, already synchronous to sram_clock.
REQ-013 SHALL have port outstanding, out, $clog2(MAX_OUTSTANDING)+1: number of reads issued but not yet returned.
REQ-014 SHALL have port idle, out, 1: high when outstanding == 0.
REQ-015 SHALL have port orphan_err, out, 1: sticky; set when data returns with no read outstanding.
REQ-016 SHALL have port credit_err, out, 1: sticky; set on a credit return while that port's credit is already full.

Function
REQ-017 SHALL drive issue_ready combinationally as (outstanding < MAX_OUTSTANDING) AND (credit[issue_port] > 0); it SHALL NOT depend on a same-cycle return.
REQ-018 SHALL accept a read when issue_valid && issue_ready: push issue_port to the tag queue tail and decrement credit[issue_port].
REQ-019 SHALL ignore issue_valid while issue_ready is low; no state change results.
REQ-020 SHALL, on sram_data_out_valid with the queue non-empty, pop the queue head and route the data to the head's port.
REQ-021 Routing SHALL be registered with 1-cycle latency: the next cycle, rX_data_din = the data and rX_data_wr_en = 1 for the head port; the other port's wr_en = 0.
REQ-022 The rX_data_din registers SHALL hold their last value when not written.
REQ-023 Returns SHALL be routed in strict issue order; the SRAM is in-order.
REQ-024 SHALL, on sram_data_out_valid with the queue empty, drop the data, assert no wr_en, and set orphan_err.
REQ-025 SHALL allow a simultaneous accept and return in one cycle: push and pop both occur and outstanding is unchanged.
REQ-026 The queue read and write pointers SHALL wrap modulo MAX_OUTSTANDING; full is outstanding == MAX_OUTSTANDING and empty is outstanding == 0.
REQ-027 Credit per port SHALL range 0..CREDITS and update each cycle as credit + ret - accept.
REQ-028 A simultaneous accept and credit return on the same port SHALL leave that port's credit unchanged.
REQ-029 A credit return at credit == CREDITS with no same-cycle accept on that port SHALL leave credit at CREDITS and set credit_err.
REQ-030 orphan_err and credit_err SHALL clear only on reset.

Reset
REQ-031 Reset SHALL set outstanding to 0, both pointers to 0, both credits to CREDITS, r0/r1_data_wr_en to 0, r0/r1_data_din to 0, orphan_err and credit_err to 0, and idle to 1.
REQ-032 Reset mid-operation SHALL discard all outstanding tags; data returning after reset is orphaned per REQ-024.
REQ-033 While reset is high, issue_valid, sram_data_out_valid and the credit returns SHALL be ignored, and issue_ready SHALL be 0.

Verification
REQ-034 Issue r0, r1, r0 on back-to-back cycles, then return 0xA, 0xB, 0xC -> one cycle after each return: r0 gets 0xA, r1 gets 0xB, r0 gets 0xC; outstanding goes 3 -> 0; idle = 1.
REQ-035 Issue 8 r0 reads with no returns (default parameters) -> issue_ready = 0 with outstanding = 8; ninth issue_valid is ignored; a return in the same cycle as issue_valid still leaves issue_ready = 0.
REQ-036 Issue 16 r1 reads, returning each -> issue_ready = 0 for port 1 and 1 for port 0; one r1_credit_ret pulse -> r1 issue_ready = 1 the next cycle.
REQ-037 Hold outstanding = 4 and pulse one issue plus one return in the same cycle -> outstanding stays 4 and routing order is preserved across pointer wrap (run more than 8 total reads).
REQ-038 Return 0xDEAD with no read outstanding -> no wr_en and orphan_err = 1; r0_credit_ret at credit 16 -> credit_err = 1; both errors persist until reset.
REQ-039 Assert reset with 3 reads outstanding, then return data -> outstanding = 0 and credits = 16 after reset; the later return sets orphan_err.

Source files
------------

// File: rtl/sram_read_tracker.sv
// Tracks in-order SRAM reads for two requesters: tags each issued read with its port,
// routes returning data to that port's FIFO one cycle later, and meters per-port FIFO credits.
module sram_read_tracker #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CREDITS         = 16
) (
  input  logic                               sram_clock,
  input  logic                               reset,
  input  logic                               issue_valid,
  input  logic                               issue_port,
  output logic                               issue_ready,
  input  logic [31:0]                        sram_data_out,
  input  logic                               sram_data_out_valid,
  output logic [31:0]                        r0_data_din,
  output logic [31:0]                        r1_data_din,
  output logic                               r0_data_wr_en,
  output logic                               r1_data_wr_en,
  input  logic                               r0_credit_ret,
  input  logic                               r1_credit_ret,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               idle,
  output logic                               orphan_err,
  output logic                               credit_err
);

  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CRED_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  logic                tag_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CRED_W-1:0]   credit_q [2];
  logic [CRED_W-1:0]   credit_d [2];
  logic [31:0]         din_q [2];
  logic [31:0]         din_d [2];
  logic [1:0]          wr_en_q, wr_en_d;
  logic                orphan_q, credit_err_q;
  logic                cerr_set;

  logic       accept, ret, orphan, head;
  logic [1:0] cret;

  assign cret = {r1_credit_ret, r0_credit_ret};

  // Readiness looks only at registered state, so a same-cycle return never opens a slot.
  assign issue_ready = !reset && (cnt_q < MAX_CNT) && (credit_q[issue_port] != '0);
  assign accept      = issue_valid && issue_ready;
  assign ret         = sram_data_out_valid && (cnt_q != '0);
  assign orphan      = sram_data_out_valid && (cnt_q == '0);
  assign head        = tag_q[rd_ptr_q];

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    cnt_d    = cnt_q;
    wr_en_d  = '0;
    din_d    = din_q;
    credit_d = credit_q;
    cerr_set = 1'b0;

    if (accept && !ret)      cnt_d = cnt_q + CNT_W'(1);
    else if (ret && !accept) cnt_d = cnt_q - CNT_W'(1);

    if (ret) begin
      wr_en_d[head] = 1'b1;
      din_d[head]   = sram_data_out;
    end

    for (int p = 0; p < 2; p++) begin
      if (cret[p] && !(accept && (issue_port == 1'(p)))) begin
        if (credit_q[p] == CRED_MAX) cerr_set = 1'b1;
        else                         credit_d[p] = credit_q[p] + CRED_W'(1);
      end else if (!cret[p] && accept && (issue_port == 1'(p))) begin
        credit_d[p] = credit_q[p] - CRED_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      wr_en_q      <= '0;
      orphan_q     <= 1'b0;
      credit_err_q <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        credit_q[p] <= CRED_MAX;
        din_q[p]    <= '0;
      end
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (ret)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q        <= cnt_d;
      wr_en_q      <= wr_en_d;
      din_q        <= din_d;
      credit_q     <= credit_d;
      orphan_q     <= orphan_q | orphan;
      credit_err_q <= credit_err_q | cerr_set;
    end
  end

  // NOTE: the tag storage is not reset; entries are only read between their push and pop.
  always_ff @(posedge sram_clock) begin
    if (accept) tag_q[wr_ptr_q] <= issue_port;
  end

  assign r0_data_din   = din_q[0];
  assign r1_data_din   = din_q[1];
  assign r0_data_wr_en = wr_en_q[0];
  assign r1_data_wr_en = wr_en_q[1];
  assign outstanding   = cnt_q;
  assign idle          = (cnt_q == '0);
  assign orphan_err    = orphan_q;
  assign credit_err    = credit_err_q;

endmodule

// File: tb/tb_sram_read_tracker.sv
// Directed bench for sram_read_tracker: a reference model predicts routing, counts,
// credits and error flags; routed returns pass through a scoreboard queue.
module tb_sram_read_tracker;

  localparam int MAXO = 8;
  localparam int CRED = 16;

  logic        clk = 1'b0;
  logic        reset, issue_valid, issue_port, issue_ready;
  logic [31:0] sram_data_out;
  logic        sram_data_out_valid;
  logic [31:0] r0_data_din, r1_data_din;
  logic        r0_data_wr_en, r1_data_wr_en;
  logic        r0_credit_ret, r1_credit_ret;
  logic [3:0]  outstanding;
  logic        idle, orphan_err, credit_err;

  always #5 clk = ~clk;

  sram_read_tracker #(.MAX_OUTSTANDING(MAXO), .CREDITS(CRED)) dut (
    .sram_clock(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_port(issue_port), .issue_ready(issue_ready),
    .sram_data_out(sram_data_out), .sram_data_out_valid(sram_data_out_valid),
    .r0_data_din(r0_data_din), .r1_data_din(r1_data_din),
    .r0_data_wr_en(r0_data_wr_en), .r1_data_wr_en(r1_data_wr_en),
    .r0_credit_ret(r0_credit_ret), .r1_credit_ret(r1_credit_ret),
    .outstanding(outstanding), .idle(idle),
    .orphan_err(orphan_err), .credit_err(credit_err)
  );

  typedef struct {
    logic        port;
    logic [31:0] data;
  } ret_t;

  ret_t        sb[$];
  logic        tag_m[$];
  int          out_m;
  int          cred_m[2];
  logic [31:0] din_m[2];
  logic        orphan_m, cerr_m;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check ready, advance model and DUT, compare outputs.
  task automatic step(input logic rst, input logic iv, input logic ip, input logic dv,
                      input logic [31:0] d, input logic c0, input logic c1);
    logic exp_rdy, acc, rt, a, r;
    ret_t e;
    reset = rst; issue_valid = iv; issue_port = ip;
    sram_data_out_valid = dv; sram_data_out = d;
    r0_credit_ret = c0; r1_credit_ret = c1;
    #1;
    exp_rdy = !rst && (out_m < MAXO) && (cred_m[ip] > 0);
    chk("issue_ready", 32'(issue_ready), 32'(exp_rdy));
    acc = iv && exp_rdy;
    @(posedge clk);
    #1;
    if (rst) begin
      tag_m.delete(); sb.delete();
      out_m = 0; cred_m[0] = CRED; cred_m[1] = CRED;
      din_m[0] = '0; din_m[1] = '0;
      orphan_m = 1'b0; cerr_m = 1'b0;
    end else begin
      rt = dv && (tag_m.size() > 0);
      if (dv && !rt) orphan_m = 1'b1;
      if (rt) begin
        e.port = tag_m.pop_front();
        e.data = d;
        sb.push_back(e);
      end
      if (acc) tag_m.push_back(ip);
      out_m = out_m + int'(acc) - int'(rt);
      for (int p = 0; p < 2; p++) begin
        a = acc && (ip == 1'(p));
        r = (p == 0) ? c0 : c1;
        if (r && !a && cred_m[p] == CRED) cerr_m = 1'b1;
        else cred_m[p] = cred_m[p] + int'(r) - int'(a);
      end
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      din_m[e.port] = e.data;
      chk("r0_wr_en", 32'(r0_data_wr_en), 32'(e.port == 1'b0));
      chk("r1_wr_en", 32'(r1_data_wr_en), 32'(e.port == 1'b1));
    end else begin
      chk("r0_wr_en_idle", 32'(r0_data_wr_en), 32'(0));
      chk("r1_wr_en_idle", 32'(r1_data_wr_en), 32'(0));
    end
    chk("r0_din", r0_data_din, din_m[0]);
    chk("r1_din", r1_data_din, din_m[1]);
    chk("outstanding", 32'(outstanding), 32'(out_m));
    chk("idle", 32'(idle), 32'(out_m == 0));
    chk("orphan_err", 32'(orphan_err), 32'(orphan_m));
    chk("credit_err", 32'(credit_err), 32'(cerr_m));
  endtask

  task automatic issue(input logic p);
    step(1'b0, 1'b1, p, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic give(input logic [31:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic refill();
    while (cred_m[0] < CRED) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    while (cred_m[1] < CRED) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    out_m = 0; cred_m[0] = CRED; cred_m[1] = CRED;
    din_m[0] = '0; din_m[1] = '0; orphan_m = 1'b0; cerr_m = 1'b0;

    // Reset, with every input active to show they are ignored.
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h1234, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    nop();

    // In-order routing of three reads to alternating ports.
    issue(1'b0); issue(1'b1); issue(1'b0);
    give(32'hA); give(32'hB); give(32'hC);
    nop();
    refill();

    // Fill the tag queue; further issues are refused even with a same-cycle return.
    for (int i = 0; i < MAXO; i++) issue(1'b0);
    issue(1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    for (int i = 1; i < MAXO; i++) give(32'h100 + 32'(i));
    refill();

    // Exhaust port-1 credits, then restore one.
    issue(1'b1);
    for (int i = 0; i < CRED - 1; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    give(32'h2FF);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    refill();

    // Steady occupancy of 4 with simultaneous issue and return across pointer wrap.
    for (int i = 0; i < 4; i++) issue(1'(i));
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'(i + 1), 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) give($urandom);
    refill();

    // Accept and credit return on the same port in one cycle.
    issue(1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    give(32'h300); give(32'h301);
    refill();

    // Orphan return and credit overflow; both flags stay set.
    give(32'hDEAD);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    issue(1'b1); give(32'h400);
    nop(); nop();
    refill();

    // Reset with reads outstanding; a late return is orphaned and credits are full.
    issue(1'b0); issue(1'b1); issue(1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h55, 1'b1, 1'b1);
    nop();
    give(32'h77);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    issue(1'b0); give(32'h88);
    nop();

    reset = 1'b0; issue_valid = 1'b0; sram_data_out_valid = 1'b0;
    r0_credit_ret = 1'b0; r1_credit_ret = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
